ff_mem_bank_pipe: RTL and testbench
===================================

# ff_mem_bank_pipe

Parametrised flip-flop memory bank with independent write and read ports, per-byte write strobes and a registered read path. It replaces the fixed 8x8 single-port bank wherever a small register-file-style store is needed. It also adds error reporting for out-of-range accesses and a saturating error counter for debug visibility.

## Interface

Parameters:
- DATA_W, default 32: data width in bits; must be a multiple of 8.
- DEPTH, default 16: number of entries; any value from 2 upward, not required to be a power of two.
- ADDR_W, default $clog2(DEPTH): address width.

Ports:
- clk  input  1  single clock; all state is updated on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- wr  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd  input  1  read enable.
- rd_addr  input  ADDR_W  read address.
- clr  input  1  synchronous clear of all entries and of err_cnt.
- rd_valid  output  1  pulses one cycle after an accepted read.
- rd_data  output  DATA_W  read result; 0 whenever rd_valid is 0.
- rd_err  output  1  qualifies rd_valid; the read address was out of range.
- wr_err  output  1  one-cycle pulse; the previous cycle's write was dropped.
- err_cnt  output  8  saturating count of error cycles.

## Operation

- **Storage:** DEPTH x DATA_W flip-flops. All entries reset to 0 asynchronously on resetn=0.
- **Write:** when wr=1, wr_addr<DEPTH and clr=0, each byte lane with wr_be[i]=1 takes wr_data; lanes with wr_be[i]=0 keep their value. wr_be=0 is a legal no-op and not an error.
- **Dropped writes:** a write is dropped and wr_err pulses on the next cycle when wr=1 and either wr_addr>=DEPTH or clr=1.
- **Read:** when rd=1, the next cycle gives rd_valid=1 and rd_data=mem[rd_addr].
  - If rd_addr>=DEPTH, rd_data=0 and rd_err=1.
  - Reads are never blocked; a read in the same cycle as clr returns the pre-clear contents.
- **Simultaneous read and write:** allowed, including to the same address. The same-address result is set by the configuration below. The combination is never an error.
- **Clear:** clr=1 zeroes every entry and err_cnt at the clock edge. clr takes precedence over wr.
- **Error counter:**
  - err_cnt increments by exactly 1 in any cycle with an error event: an out-of-range read, an out-of-range write, or a write dropped by clr.
  - Two events in the same cycle still count once.
  - err_cnt saturates at 255 and never wraps.
  - In a cycle with both clr and an error event, err_cnt ends at 1.
- **Datapath:** no arithmetic beyond the 8-bit saturating increment. Address compares are unsigned.

## Timing

- **Reset values:** rd_valid=0, rd_data=0, rd_err=0, wr_err=0, err_cnt=0, all entries 0.
  - Assertion takes effect immediately and is independent of clk.
  - Release is expected to be synchronised externally; the first rising edge after release is an ordinary cycle.
- **Write latency:** 1 cycle. Data written at edge N is readable by a read issued in cycle N+1 (sampled at edge N+1) and appears on rd_data in cycle N+2.
- **Read latency:** 1 cycle. rd=1 sampled at edge N gives rd_valid, rd_data and rd_err valid after edge N, for exactly one cycle.
  - Back-to-back reads produce back-to-back valids.
- **wr_err:** registered; it pulses for one cycle after the offending edge.
- **Reset mid-operation:** an in-flight read is discarded and rd_valid goes to 0 immediately. Memory contents are lost.
- There is no backpressure: the consumer must accept rd_data in the cycle rd_valid=1.

## Configuration

- Macro: `FF_MEM_BANK_PIPE_FWD_EN`.
- **Defined:** a same-cycle read and write to the same in-range address with clr=0 returns the forwarded value on rd_data. Bytes with wr_be=1 come from wr_data; the other bytes come from the old entry.
- **Undefined:** that same case returns the old entry contents (read-before-write). This costs no forwarding mux.
- All other behaviour is identical with or without the macro.

## Test plan

Defaults DATA_W=32, DEPTH=12 apply to every scenario.

- **Reset:** drive resetn=0 mid-cycle with rd_valid=1 → all outputs read 0 before the next edge. Then read addr 5 → rd_data=0x00000000.
- **Byte strobes:**
  - Write 0xAABBCCDD to addr 3 with wr_be=4'b1111.
  - Then write 0x11223344 to addr 3 with wr_be=4'b0101.
  - Then read addr 3 → rd_data=0xAA22CC44, rd_valid=1 for exactly one cycle.
- **Collision:** addr 7 holds 0x0; write 0xDEADBEEF with wr_be=4'b1111 and read addr 7 in the same cycle.
  - With `FF_MEM_BANK_PIPE_FWD_EN` → rd_data=0xDEADBEEF.
  - Without it → rd_data=0x00000000.
  - The next read of addr 7 gives 0xDEADBEEF in both builds.
- **Out of range:**
  - Write to addr 12 → wr_err pulses once and err_cnt=1.
  - Read addr 15 → rd_valid=1, rd_err=1, rd_data=0 and err_cnt=2.
  - Entries 0..11 are unchanged.
- **Clear priority:** fill all entries, then assert clr with wr to addr 2 in the same cycle → wr_err pulses, err_cnt=1, and subsequent reads of all 12 entries return 0.
- **Saturation:** issue 300 consecutive out-of-range reads → err_cnt=255 and held. A single clr → err_cnt=0.

Source files
------------

// File: rtl/ff_mem_bank_pipe.sv
// ff_mem_bank_pipe: DEPTH x DATA_W flip-flop bank with a byte-strobed write port and a registered read port.
// Define FF_MEM_BANK_PIPE_FWD_EN to forward same-cycle write data to a read of the same address.
module ff_mem_bank_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                clr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_err,
    output logic                wr_err,
    output logic [7:0]          err_cnt
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              wr_drop;
    logic              rd_oor;
    logic              err_evt;

    // Widen addresses by one bit so DEPTH itself is representable in the compare.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign wr_ok       = wr && wr_in_range && !clr;
    assign wr_drop     = wr && (!wr_in_range || clr);
    assign rd_oor      = rd && !rd_in_range;
    assign err_evt     = wr_drop || rd_oor;

    // NOTE: the entries are plain flops, so they can take the async reset; a RAM macro could not.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (wr_be[b]) mem[i][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // NOTE: rd_word gets a default before any conditional write so no latch is inferred.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_word = mem[i];
        end
`ifdef FF_MEM_BANK_PIPE_FWD_EN
        if (wr_ok && rd && (wr_addr == rd_addr)) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd;
            rd_data  <= (rd && rd_in_range) ? rd_word : '0;
            rd_err   <= rd_oor;
            wr_err   <= wr_drop;
        end
    end

    // A clear wipes history, but an error in the clearing cycle is still recorded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt <= 8'd0;
        end else if (clr) begin
            err_cnt <= err_evt ? 8'd1 : 8'd0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ff_mem_bank_pipe.sv
// Self-checking bench for ff_mem_bank_pipe (DATA_W=32, DEPTH=12): directed scenarios plus
// randomized traffic, all compared against an array-based behavioural model.
module tb_ff_mem_bank_pipe;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              resetn;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_be;
    logic              rd;
    logic [ADDR_W-1:0] rd_addr;
    logic              clr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              wr_err;
    logic [7:0]        err_cnt;

    logic [31:0] m_mem [DEPTH];
    int          m_err;
    int          total;
    int          bad;

    ff_mem_bank_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr       (wr),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd       (rd),
        .rd_addr  (rd_addr),
        .clr      (clr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .wr_err   (wr_err),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_err = 0;
    endtask

    // One clock cycle: drive inputs, predict outputs from the model, check after the edge.
    task automatic do_cycle(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                            input logic [3:0] be, input logic r, input logic [3:0] ra,
                            input logic c);
        logic [31:0] old_word;
        logic [31:0] e_data;
        logic        w_drop;
        logic        r_oor;
        logic        evt;
        int          wi;
        int          ri;
        wr = w; wr_addr = wa; wr_data = wd; wr_be = be;
        rd = r; rd_addr = ra; clr = c;
        wi = int'(wa);
        ri = int'(ra);
        r_oor  = r && (ri >= DEPTH);
        w_drop = w && ((wi >= DEPTH) || c);
        evt    = r_oor || w_drop;
        old_word = (ri < DEPTH) ? m_mem[ri] : 32'h0;
        if (w && !w_drop) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_mem[wi][8*b +: 8] = wd[8*b +: 8];
            end
        end
        e_data = 32'h0;
        if (r && !r_oor) begin
            e_data = old_word;
`ifdef FF_MEM_BANK_PIPE_FWD_EN
            if (w && !w_drop && (wi == ri)) e_data = m_mem[ri];
`endif
        end
        if (c) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            m_err = evt ? 1 : 0;
        end else if (evt && (m_err < 255)) begin
            m_err = m_err + 1;
        end
        @(posedge clk);
        #1;
        check("rd_valid", 32'(rd_valid), 32'(r));
        check("rd_data", rd_data, e_data);
        check("rd_err", 32'(rd_err), 32'(r_oor));
        check("wr_err", 32'(wr_err), 32'(w_drop));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    task automatic idle();
        do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
        check({tag, "_rd_data"}, rd_data, 32'h0);
        check({tag, "_rd_err"}, 32'(rd_err), 32'h0);
        check({tag, "_wr_err"}, 32'(wr_err), 32'h0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        wr = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd = 1'b0; rd_addr = '0; clr = 1'b0;
        model_reset();
        #3;
        check_outputs_zero("por");
        #9 resetn = 1'b1;

        // Dirty the bank, then assert reset mid-cycle while a read result is showing.
        do_cycle(1'b1, 4'd5, 32'h12345678, 4'hF, 1'b0, 4'd0, 1'b0);
        do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 1'b0);
        check("pre_reset_valid", 32'(rd_valid), 32'h1);
        rd = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        #1 resetn = 1'b1;
        do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, 1'b0);
        check("reset_addr5", rd_data, 32'h0);

        // Byte strobes.
        do_cycle(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, 4'd0, 1'b0);
        do_cycle(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0, 1'b0);
        do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, 1'b0);
        check("strobe_data", rd_data, 32'hAA22CC44);
        idle();
        check("strobe_one_pulse", 32'(rd_valid), 32'h0);
        do_cycle(1'b1, 4'd4, 32'hCAFEF00D, 4'b0000, 1'b0, 4'd0, 1'b0);
        check("be_zero_no_err", 32'(wr_err), 32'h0);

        // Same-address collision.
        do_cycle(1'b1, 4'd7, 32'hDEADBEEF, 4'b1111, 1'b1, 4'd7, 1'b0);
`ifdef FF_MEM_BANK_PIPE_FWD_EN
        check("collide_fwd", rd_data, 32'hDEADBEEF);
`else
        check("collide_rbw", rd_data, 32'h0);
`endif
        do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, 1'b0);
        check("collide_after", rd_data, 32'hDEADBEEF);

        // Out of range.
        do_cycle(1'b1, 4'd12, 32'hFFFFFFFF, 4'hF, 1'b0, 4'd0, 1'b0);
        check("oor_wr_err", 32'(wr_err), 32'h1);
        check("oor_wr_cnt", 32'(err_cnt), 32'd1);
        do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd15, 1'b0);
        check("oor_rd_err", 32'(rd_err), 32'h1);
        check("oor_rd_cnt", 32'(err_cnt), 32'd2);
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b0);

        // Clear priority over a same-cycle write.
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 4'(i), $urandom | 32'h1, 4'hF, 1'b0, 4'd0, 1'b0);
        do_cycle(1'b1, 4'd2, 32'h55AA55AA, 4'hF, 1'b0, 4'd0, 1'b1);
        check("clr_wr_err", 32'(wr_err), 32'h1);
        check("clr_cnt", 32'(err_cnt), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b0);
            check("clr_entry_zero", rd_data, 32'h0);
        end

        // Saturation of the error counter, then clear.
        for (int i = 0; i < 300; i++) do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd15, 1'b0);
        check("sat_255", 32'(err_cnt), 32'd255);
        idle();
        check("sat_hold", 32'(err_cnt), 32'd255);
        do_cycle(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b1);
        check("sat_clr", 32'(err_cnt), 32'd0);

        // Randomized traffic, including collisions, clears and out-of-range addresses.
        for (int i = 0; i < 600; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 40; i++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 11));
            do_cycle(1'b1, a, $urandom, 4'($urandom_range(0, 15)), 1'b1, a, 1'b0);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
